trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_trap_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer
// Description : Sequences a committed exception/interrupt into CSR writes
//               (cause, epc, tval, mstatus), then a single-cycle PC redirect
//               to the trap handler with a privilege update.
//               Optional macro TRAP_DELEG_EN enables medeleg-based
//               delegation of synchronous exceptions to S-mode.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer #(
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        except_valid,
  input  logic [63:0] except_epc,
  input  logic [63:0] except_cause,
  input  logic [63:0] except_tval,
  input  logic [1:0]  priv_i,
  input  logic [63:0] mstatus_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] stvec_i,
  input  logic [63:0] medeleg_i,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [63:0] csr_wdata,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [1:0]  priv_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CAUSE  = 3'd1,
    S_EPC    = 3'd2,
    S_TVAL   = 3'd3,
    S_STATUS = 3'd4,
    S_JUMP   = 3'd5
  } state_t;

  localparam logic [11:0] c_mcause_addr  = 12'h342;
  localparam logic [11:0] c_mepc_addr    = 12'h341;
  localparam logic [11:0] c_mtval_addr   = 12'h343;
  localparam logic [11:0] c_scause_addr  = 12'h142;
  localparam logic [11:0] c_sepc_addr    = 12'h141;
  localparam logic [11:0] c_stval_addr   = 12'h143;
  localparam logic [11:0] c_mstatus_addr = 12'h300;
  localparam logic [1:0]  c_priv_m       = 2'b11;
  localparam logic [1:0]  c_priv_s       = 2'b01;

  state_t      r_state;
  logic [63:0] r_epc;
  logic [63:0] r_cause;
  logic [63:0] r_tval;
  logic [1:0]  r_priv;
  logic        r_tgt_s;
  logic        r_csr_we;
  logic [11:0] r_csr_waddr;
  logic        r_flush;
  logic        r_redirect;
  logic [1:0]  r_priv_o;

  logic        w_tgt_s;
  logic [63:0] w_tvec;
  logic [63:0] w_base;
  logic [63:0] w_vec_off;
  logic [63:0] w_handler;
  logic [63:0] w_status;
  logic [63:0] w_csr_wdata;

`ifdef TRAP_DELEG_EN
  // Only synchronous exceptions from U/S with the matching medeleg bit go to S.
  assign w_tgt_s = (priv_i <= 2'd1) && !except_cause[63] && medeleg_i[except_cause[5:0]];
  assign w_tvec  = r_tgt_s ? stvec_i : mtvec_i;
`else
  logic w_unused_deleg;
  assign w_tgt_s        = 1'b0;
  assign w_tvec         = mtvec_i;
  assign w_unused_deleg = ^{medeleg_i, stvec_i};
`endif

  // Handler address: tvec base, plus 4*code for vectored-mode interrupts.
  // The tvec is read live so a CSR update landing mid-sequence is honoured.
  assign w_base    = {w_tvec[63:2], 2'b00};
  assign w_vec_off = {56'd0, r_cause[5:0], 2'b00};
  assign w_handler = ((w_tvec[1:0] == 2'b01) && r_cause[63]) ? (w_base + w_vec_off) : w_base;

  // New mstatus: stash interrupt enable and previous privilege, then disable.
  always_comb begin
    w_status = mstatus_i;
    if (r_tgt_s) begin
      w_status[8] = r_priv[0];
      w_status[5] = mstatus_i[1];
      w_status[1] = 1'b0;
    end else begin
      w_status[12:11] = r_priv;
      w_status[7]     = mstatus_i[3];
      w_status[3]     = 1'b0;
    end
  end

  // Write data follows the state; mstatus is taken from the current cycle.
  always_comb begin
    w_csr_wdata = 64'd0;
    case (r_state)
      S_CAUSE:  w_csr_wdata = r_cause;
      S_EPC:    w_csr_wdata = r_epc;
      S_TVAL:   w_csr_wdata = r_tval;
      S_STATUS: w_csr_wdata = w_status;
      default:  w_csr_wdata = 64'd0;
    endcase
  end

  // Trap FSM: latches the trap, walks the CSR writes and registers the
  // strobes/addresses for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_epc       <= 64'd0;
      r_cause     <= 64'd0;
      r_tval      <= 64'd0;
      r_priv      <= 2'd0;
      r_tgt_s     <= 1'b0;
      r_csr_we    <= 1'b0;
      r_csr_waddr <= 12'd0;
      r_flush     <= 1'b0;
      r_redirect  <= 1'b0;
      r_priv_o    <= RESET_PRIV;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (except_valid) begin
            r_epc       <= except_epc;
            r_cause     <= except_cause;
            r_tval      <= except_tval;
            r_priv      <= priv_i;
            r_tgt_s     <= w_tgt_s;
            r_csr_we    <= 1'b1;
            r_csr_waddr <= w_tgt_s ? c_scause_addr : c_mcause_addr;
            r_flush     <= 1'b1;
            r_state     <= S_CAUSE;
          end
        end
        S_CAUSE: begin
          r_csr_waddr <= r_tgt_s ? c_sepc_addr : c_mepc_addr;
          r_state     <= S_EPC;
        end
        S_EPC: begin
          r_csr_waddr <= r_tgt_s ? c_stval_addr : c_mtval_addr;
          r_state     <= S_TVAL;
        end
        S_TVAL: begin
          r_csr_waddr <= c_mstatus_addr;
          r_state     <= S_STATUS;
        end
        S_STATUS: begin
          r_csr_we    <= 1'b0;
          r_csr_waddr <= 12'd0;
          r_redirect  <= 1'b1;
          r_priv_o    <= r_tgt_s ? c_priv_s : c_priv_m;
          r_state     <= S_JUMP;
        end
        S_JUMP: begin
          r_redirect <= 1'b0;
          r_flush    <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_csr_we    <= 1'b0;
          r_csr_waddr <= 12'd0;
          r_redirect  <= 1'b0;
          r_flush     <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign csr_we         = r_csr_we;
  assign csr_waddr      = r_csr_waddr;
  assign csr_wdata      = w_csr_wdata;
  assign flush          = r_flush;
  assign busy           = r_flush;
  assign redirect_valid = r_redirect;
  assign redirect_pc    = (r_state == S_JUMP) ? w_handler : 64'd0;
  assign priv_o         = r_priv_o;

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Self-checking bench for trap_sequencer (table vectors,
//               randomized traps against a reference model, corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        except_valid;
  logic [63:0] except_epc, except_cause, except_tval;
  logic [1:0]  priv_i;
  logic [63:0] mstatus_i, mtvec_i, stvec_i, medeleg_i;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        flush, busy, redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0]  priv_o;

  int checks = 0;
  int errors = 0;

  trap_sequencer #(.RESET_PRIV(2'b11)) dut (
    .clk(clk), .rst(rst), .except_valid(except_valid),
    .except_epc(except_epc), .except_cause(except_cause), .except_tval(except_tval),
    .priv_i(priv_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .stvec_i(stvec_i),
    .medeleg_i(medeleg_i), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .flush(flush), .busy(busy), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .priv_o(priv_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] epc, cause, tval;
    logic [1:0]  priv;
    logic [63:0] mstatus, mtvec, stvec, medeleg;
    logic        exp_s;
    logic [63:0] exp_status, exp_pc;
    logic [1:0]  exp_priv;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Reference model: trap outcome straight from the architectural rules.
  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    logic [63:0] tv;
`ifdef TRAP_DELEG_EN
    o.exp_s = (v.priv <= 2'd1) && (v.cause[63] == 1'b0) && (v.medeleg[v.cause[5:0]] == 1'b1);
`else
    o.exp_s = 1'b0;
`endif
    if (o.exp_s) begin
      o.exp_status = (v.mstatus & ~64'h122) | (64'(v.priv[0]) << 8) | (64'(v.mstatus[1]) << 5);
      o.exp_priv   = 2'd1;
      tv           = v.stvec;
    end else begin
      o.exp_status = (v.mstatus & ~64'h1888) | (64'(v.priv) << 11) | (64'(v.mstatus[3]) << 7);
      o.exp_priv   = 2'd3;
      tv           = v.mtvec;
    end
    o.exp_pc = tv - (tv % 4);
    if ((tv % 4 == 1) && v.cause[63]) o.exp_pc = o.exp_pc + 4 * (v.cause % 64);
    return o;
  endfunction

  function automatic vec_t mk(input logic [63:0] epc, cause, tval, input logic [1:0] priv,
                              input logic [63:0] mst, mtv, stv, med, input logic s,
                              input logic [63:0] st, pc, input logic [1:0] np);
    vec_t v;
    v.epc = epc; v.cause = cause; v.tval = tval; v.priv = priv;
    v.mstatus = mst; v.mtvec = mtv; v.stvec = stv; v.medeleg = med;
    v.exp_s = s; v.exp_status = st; v.exp_pc = pc; v.exp_priv = np;
    return v;
  endfunction

  // Drives one trap and checks every cycle through the return to IDLE.
  // Latch-time CSR inputs are garbage; the real values appear only after
  // the trap is accepted. With hold=1 except_valid stays high to the end.
  task automatic run_trap(input vec_t v, input bit hold, input string tag);
    logic [11:0] a[4];
    logic [63:0] d[4];
    a[0] = v.exp_s ? 12'h142 : 12'h342;
    a[1] = v.exp_s ? 12'h141 : 12'h341;
    a[2] = v.exp_s ? 12'h143 : 12'h343;
    a[3] = 12'h300;
    d[0] = v.cause; d[1] = v.epc; d[2] = v.tval; d[3] = v.exp_status;
    except_valid = 1'b1;
    except_epc = v.epc; except_cause = v.cause; except_tval = v.tval;
    priv_i = v.priv; medeleg_i = v.medeleg;
    mstatus_i = r64(); mtvec_i = r64(); stvec_i = r64();
    step();
    except_valid = hold;
    except_epc = r64(); except_cause = r64(); except_tval = r64();
    priv_i = 2'($urandom); medeleg_i = r64();
    mstatus_i = v.mstatus; mtvec_i = v.mtvec; stvec_i = v.stvec;
    for (int i = 0; i < 4; i++) begin
      chk({tag, " we"}, 64'(csr_we), 64'd1);
      chk({tag, " waddr"}, 64'(csr_waddr), 64'(a[i]));
      chk({tag, " wdata"}, csr_wdata, d[i]);
      chk({tag, " flush/busy"}, {62'd0, flush, busy}, 64'd3);
      chk({tag, " redir early"}, 64'(redirect_valid), 64'd0);
      step();
    end
    chk({tag, " redir"}, 64'(redirect_valid), 64'd1);
    chk({tag, " pc"}, redirect_pc, v.exp_pc);
    chk({tag, " we in jump"}, {51'd0, csr_we, csr_waddr}, 64'd0);
    chk({tag, " wdata in jump"}, csr_wdata, 64'd0);
    chk({tag, " flush in jump"}, 64'(flush), 64'd1);
    step();
    except_valid = 1'b0;
    chk({tag, " idle outs"}, {60'd0, redirect_valid, flush, busy, csr_we}, 64'd0);
    chk({tag, " idle pc"}, redirect_pc, 64'd0);
    chk({tag, " priv_o"}, 64'(priv_o), 64'(v.exp_priv));
    step();
    chk({tag, " no retrigger"}, {62'd0, flush, csr_we}, 64'd0);
  endtask

  initial begin
    int nwe, nred, nfl;
    vec_t v;
    rst = 1'b1; except_valid = 1'b0;
    except_epc = '0; except_cause = '0; except_tval = '0; priv_i = '0;
    mstatus_i = '0; mtvec_i = '0; stvec_i = '0; medeleg_i = '0;

    tbl[0] = mk(64'h80000010, 64'd2, 64'hFFFF, 2'd3, 64'h8, 64'h80001000, 64'h80200000,
                64'h104, 1'b0, 64'h1880, 64'h80001000, 2'd3);
    tbl[1] = mk(64'h80000100, 64'h8000000000000007, 64'd0, 2'd3, 64'h0, 64'h80001001,
                64'h80200000, 64'h0, 1'b0, 64'h1800, 64'h8000101C, 2'd3);
`ifdef TRAP_DELEG_EN
    tbl[2] = mk(64'h1000, 64'd8, 64'd0, 2'd0, 64'h2, 64'h80001000, 64'h80200000,
                64'h100, 1'b1, 64'h20, 64'h80200000, 2'd1);
    tbl[5] = mk(64'h3000, 64'hD, 64'h77, 2'd1, 64'hA, 64'h80001001, 64'h80200001,
                64'h2000, 1'b1, 64'h128, 64'h80200000, 2'd1);
`else
    tbl[2] = mk(64'h1000, 64'd8, 64'd0, 2'd0, 64'h2, 64'h80001000, 64'h80200000,
                64'h100, 1'b0, 64'h2, 64'h80001000, 2'd3);
    tbl[5] = mk(64'h3000, 64'hD, 64'h77, 2'd1, 64'hA, 64'h80001001, 64'h80200001,
                64'h2000, 1'b0, 64'h882, 64'h80001000, 2'd3);
`endif
    tbl[3] = mk(64'h2000, 64'h800000000000003F, 64'h5, 2'd1, 64'hFFFFFFFFFFFFFFFF,
                64'hFFFFFFFFFFFFFFFD, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0,
                64'hFFFFFFFFFFFFEFF7, 64'hF8, 2'd3);
    tbl[4] = mk(64'h4000, 64'h8000000000000005, 64'd0, 2'd0, 64'h8, 64'h80001002,
                64'h0, 64'h0, 1'b0, 64'h80, 64'h80001000, 2'd3);
    tbl[6] = mk(64'h5000, 64'd8, 64'd0, 2'd2, 64'h0, 64'h80001000, 64'h80200000,
                64'h100, 1'b0, 64'h1000, 64'h80001000, 2'd3);

    // Reset state
    step(); step();
    chk("reset priv_o", 64'(priv_o), 64'd3);
    chk("reset ctrl", {59'd0, csr_we, flush, busy, redirect_valid, 1'b0}, 64'd0);
    chk("reset waddr", 64'(csr_waddr), 64'd0);
    chk("reset wdata", csr_wdata, 64'd0);
    chk("reset pc", redirect_pc, 64'd0);
    rst = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < 7; i++) run_trap(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // Randomized traps against the reference model
    for (int n = 0; n < 40; n++) begin
      v.epc = r64(); v.tval = r64(); v.priv = 2'($urandom);
      v.cause = 64'($urandom_range(0, 63)) | ({63'd0, 1'($urandom)} << 63);
      v.mstatus = r64(); v.mtvec = r64(); v.stvec = r64(); v.medeleg = r64();
      if ($urandom_range(0, 1) == 1) v.mtvec[1:0] = 2'b01;
      if ($urandom_range(0, 1) == 1) v.stvec[1:0] = 2'b01;
      run_trap(model(v), 1'b0, $sformatf("rnd%0d", n));
    end

    // except_valid held through the whole sequence is ignored
    run_trap(tbl[0], 1'b1, "hold");

    // Reset during TVAL aborts the sequence
    run_trap(tbl[2], 1'b0, "pre-abort");
    except_valid = 1'b1;
    except_epc = tbl[0].epc; except_cause = tbl[0].cause; except_tval = tbl[0].tval;
    priv_i = tbl[0].priv; mstatus_i = tbl[0].mstatus; mtvec_i = tbl[0].mtvec;
    step();
    except_valid = 1'b0;
    step(); step();
    chk("abort at tval", 64'(csr_waddr), 64'h343);
    rst = 1'b1;
    #1;
    chk("abort async ctrl", {60'd0, csr_we, flush, busy, redirect_valid}, 64'd0);
    chk("abort priv_o", 64'(priv_o), 64'd3);
    step();
    rst = 1'b0;
    nwe = 0; nred = 0; nfl = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      nwe += int'(csr_we); nred += int'(redirect_valid); nfl += int'(flush);
    end
    chk("abort writes", 64'(nwe), 64'd0);
    chk("abort redirects", 64'(nred), 64'd0);
    chk("abort flush", 64'(nfl), 64'd0);
    chk("abort priv_o after", 64'(priv_o), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
